// File: rtl/snd_cmd_latch_if.sv
// Command/Z80 bus bundle for snd_cmd_latch.
// slave = latch side, master = 68000 + Z80 side.
interface snd_cmd_latch_if;
    logic        SNDDT;
    logic        SNDON;
    logic [7:0]  CPU_DIN;
    logic [15:0] Z80_A;
    logic        Z80_nMREQ;
    logic        Z80_nIORQ;
    logic        Z80_nRD;
    logic        Z80_nM1;
    logic        Z80_nIRQ;
    logic [7:0]  Z80_DOUT;
    logic        Z80_DOE;
    logic        PENDING;
    logic        OVERRUN;

    modport slave (
        input  SNDDT, SNDON, CPU_DIN,
        input  Z80_A, Z80_nMREQ, Z80_nIORQ,
        input  Z80_nRD, Z80_nM1,
        output Z80_nIRQ, Z80_DOUT, Z80_DOE,
        output PENDING, OVERRUN
    );

    modport master (
        output SNDDT, SNDON, CPU_DIN,
        output Z80_A, Z80_nMREQ, Z80_nIORQ,
        output Z80_nRD, Z80_nM1,
        input  Z80_nIRQ, Z80_DOUT, Z80_DOE,
        input  PENDING, OVERRUN
    );
endinterface

// File: rtl/snd_cmd_latch.sv
// 68000 -> Z80 sound command latch.
// Captures code on SNDDT release, raises Z80 IRQ on SNDON rise.
module snd_cmd_latch #(
    parameter logic [15:0] LATCH_ADDR  = 16'hA000,
    parameter logic [15:0] STATUS_ADDR = 16'hA001
) (
    input  logic            clk_24M,
    input  logic            nRES,
    snd_cmd_latch_if.slave  bus
);

    logic [7:0] cmd;
    logic [7:0] shadow;
    logic       nirq;
    logic       pending;
    logic       overrun;

    logic       snddt_q;
    logic       sndon_q;
    logic       ack_q;
    logic       rd_latch_q;
    logic       rd_status_q;

    logic       rd_latch;
    logic       rd_status;
    logic       ack;
    logic       capture;
    logic       sndon_rise;
    logic       ack_edge;
    logic       latch_rd_end;
    logic       status_rd_end;
    logic       ov_set;

    assign rd_latch  = ~bus.Z80_nMREQ & ~bus.Z80_nRD
                     & (bus.Z80_A == LATCH_ADDR);
    assign rd_status = ~bus.Z80_nMREQ & ~bus.Z80_nRD
                     & (bus.Z80_A == STATUS_ADDR);
    assign ack       = ~bus.Z80_nM1 & ~bus.Z80_nIORQ;

    assign capture       = bus.SNDDT & ~snddt_q;
    assign sndon_rise    = bus.SNDON & ~sndon_q;
    assign ack_edge      = ack & ~ack_q;
    assign latch_rd_end  = rd_latch_q & ~rd_latch;
    assign status_rd_end = rd_status_q & ~rd_status;

    // An unread byte consumed on this same clock is not an overrun.
    assign ov_set = capture & pending & ~latch_rd_end;

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            snddt_q     <= 1'b1;
            sndon_q     <= 1'b0;
            ack_q       <= 1'b0;
            rd_latch_q  <= 1'b0;
            rd_status_q <= 1'b0;
        end else begin
            snddt_q     <= bus.SNDDT;
            sndon_q     <= bus.SNDON;
            ack_q       <= ack;
            rd_latch_q  <= rd_latch;
            rd_status_q <= rd_status;
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            shadow <= 8'h00;
            cmd    <= 8'h00;
        end else begin
            if (!bus.SNDDT) shadow <= bus.CPU_DIN;
            if (capture)    cmd    <= shadow;
        end
    end

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (capture)           pending <= 1'b1;
            else if (latch_rd_end) pending <= 1'b0;

            if (ov_set)             overrun <= 1'b1;
            else if (status_rd_end) overrun <= 1'b0;
        end
    end

    // Set beats ack so a fresh request is never dropped.
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES)           nirq <= 1'b1;
        else if (sndon_rise) nirq <= 1'b0;
        else if (ack_edge)   nirq <= 1'b1;
    end

    always_comb begin
        bus.Z80_DOUT = 8'h00;
        if (rd_latch)       bus.Z80_DOUT = cmd;
        else if (rd_status) bus.Z80_DOUT = {overrun, pending, 6'b000000};
    end

    assign bus.Z80_DOE  = rd_latch | rd_status;
    assign bus.Z80_nIRQ = nirq;
    assign bus.PENDING  = pending;
    assign bus.OVERRUN  = overrun;

endmodule
